// File: rtl/vga_timing_gen.sv
// VGA raster timing: pixel divider, h/v counters, zero-skew sync/blank decode,
// frame marker and the 'troca' animation-phase bit.
module vga_timing_gen #(
  parameter int PIX_DIV      = 2,
  parameter int H_ACTIVE     = 640,
  parameter int H_FP         = 16,
  parameter int H_SYNC       = 96,
  parameter int H_BP         = 48,
  parameter int V_ACTIVE     = 480,
  parameter int V_FP         = 10,
  parameter int V_SYNC       = 2,
  parameter int V_BP         = 33,
  parameter int TROCA_FRAMES = 30
) (
  input  logic       clk,
  input  logic       reset,
  output logic       pix_en,
  output logic [9:0] h_counter,
  output logic [9:0] v_counter,
  output logic       hsync,
  output logic       vsync,
  output logic       active_video,
  output logic       frame_start,
  output logic       troca
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
  localparam int FC_W    = $clog2(TROCA_FRAMES + 1);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PIX_DIV - 1);
  localparam logic [FC_W-1:0]  FC_LAST  = FC_W'(TROCA_FRAMES - 1);
  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
  localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

  logic [DIV_W-1:0] div;
  logic [FC_W-1:0]  frame_cnt;
  logic [9:0]       h_nxt;
  logic [9:0]       v_nxt;
  logic             h_wrap;
  logic             frame_wrap;

  assign pix_en = (div == DIV_LAST);

  always_comb begin
    h_wrap     = pix_en && (h_counter == H_LAST);
    frame_wrap = h_wrap && (v_counter == V_LAST);
    h_nxt      = h_counter;
    v_nxt      = v_counter;
    if (pix_en) begin
      h_nxt = (h_counter == H_LAST) ? 10'd0 : h_counter + 10'd1;
    end
    if (h_wrap) begin
      v_nxt = (v_counter == V_LAST) ? 10'd0 : v_counter + 10'd1;
    end
  end

  // Sync and blanking decode the next-state counters so they line up with h/v.
  always_ff @(posedge clk) begin
    if (reset) begin
      div          <= '0;
      h_counter    <= '0;
      v_counter    <= '0;
      hsync        <= 1'b1;
      vsync        <= 1'b1;
      active_video <= 1'b1;
      frame_start  <= 1'b0;
      frame_cnt    <= '0;
      troca        <= 1'b0;
    end else begin
      div          <= pix_en ? '0 : div + 1'b1;
      h_counter    <= h_nxt;
      v_counter    <= v_nxt;
      hsync        <= !((h_nxt >= HS_START) && (h_nxt < HS_END));
      vsync        <= !((v_nxt >= VS_START) && (v_nxt < VS_END));
      active_video <= (h_nxt < H_ACT) && (v_nxt < V_ACT);
      frame_start  <= frame_wrap;
      if (frame_wrap) begin
        if (frame_cnt == FC_LAST) begin
          frame_cnt <= '0;
          troca     <= ~troca;
        end else begin
          frame_cnt <= frame_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen on a shrunken raster (15x11), run as a
// PIX_DIV=2 build and a PIX_DIV=1 build side by side.
module tb_vga_timing_gen;

  localparam int HA = 8, HF = 2, HS = 3, HB = 2;
  localparam int VA = 6, VF = 2, VS = 2, VB = 1;
  localparam int HT = HA + HF + HS + HB;   // 15
  localparam int VT = VA + VF + VS + VB;   // 11
  localparam int TR = 3;
  localparam int R0 = 862;                 // mid-run reset start (3 clk wide)
  localparam int NCYC = 2205;

  typedef struct packed {
    logic       pix_en;
    logic [9:0] h;
    logic [9:0] v;
    logic       hsync;
    logic       vsync;
    logic       av;
    logic       fs;
    logic       troca;
  } exp_t;

  logic clk = 1'b0;
  logic reset;

  logic       pe2, hs2, vs2, av2, fs2, tr2;
  logic [9:0] h2, v2;
  logic       pe1, hs1, vs1, av1, fs1, tr1;
  logic [9:0] h1, v1;

  exp_t q2[$];
  exp_t q1[$];
  int   compared = 0;
  int   mismatched = 0;
  int   fs_cnt2 = 0, fs_cnt1 = 0, tr_rise2 = 0, tr_rise1 = 0;
  logic tr_prev2 = 1'b0, tr_prev1 = 1'b0;

  always #5 clk = ~clk;

  vga_timing_gen #(.PIX_DIV(2), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
                   .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .TROCA_FRAMES(TR))
  dut2 (.clk(clk), .reset(reset), .pix_en(pe2), .h_counter(h2), .v_counter(v2),
        .hsync(hs2), .vsync(vs2), .active_video(av2), .frame_start(fs2), .troca(tr2));

  vga_timing_gen #(.PIX_DIV(1), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
                   .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .TROCA_FRAMES(TR))
  dut1 (.clk(clk), .reset(reset), .pix_en(pe1), .h_counter(h1), .v_counter(v1),
        .hsync(hs1), .vsync(vs1), .active_video(av1), .frame_start(fs1), .troca(tr1));

  // Expected outputs c clocks after the last reset edge, from the pixel index.
  function automatic exp_t model(int c, int pd);
    exp_t e;
    int k, ph, hh, vv, f;
    k  = c / pd;
    ph = c % pd;
    hh = k % HT;
    vv = (k / HT) % VT;
    f  = k / (HT * VT);
    e.pix_en = (ph == pd - 1);
    e.h      = 10'(hh);
    e.v      = 10'(vv);
    e.hsync  = !(hh >= HA + HF && hh < HA + HF + HS);
    e.vsync  = !(vv >= VA + VF && vv < VA + VF + VS);
    e.av     = (hh < HA) && (vv < VA);
    e.fs     = (ph == 0) && (k > 0) && (hh == 0) && (vv == 0);
    e.troca  = ((f / TR) % 2) == 1;
    return e;
  endfunction

  task automatic check_rec(input int id, input exp_t got, input exp_t e);
    compared++;
    if (got !== e) begin
      mismatched++;
      $display("FAIL scoreboard dut_pd%0d t=%0t got pe=%b h=%0d v=%0d hs=%b vs=%b av=%b fs=%b tr=%b required pe=%b h=%0d v=%0d hs=%b vs=%b av=%b fs=%b tr=%b",
               id, $time, got.pix_en, got.h, got.v, got.hsync, got.vsync, got.av, got.fs, got.troca,
               e.pix_en, e.h, e.v, e.hsync, e.vsync, e.av, e.fs, e.troca);
    end
  endtask

  task automatic check_int(input string name, input int got, input int req);
    compared++;
    if (got != req) begin
      mismatched++;
      $display("FAIL %s got %0d required %0d", name, got, req);
    end
  endtask

  // Monitor: every clock the DUTs present a raster state; pop and compare.
  initial begin
    exp_t e, got;
    forever begin
      @(negedge clk);
      if (q2.size() > 0) begin
        e   = q2.pop_front();
        got = {pe2, h2, v2, hs2, vs2, av2, fs2, tr2};
        check_rec(2, got, e);
        if (fs2 === 1'b1) fs_cnt2++;
        if (tr2 === 1'b1 && tr_prev2 == 1'b0) tr_rise2++;
        tr_prev2 = tr2;
      end
      if (q1.size() > 0) begin
        e   = q1.pop_front();
        got = {pe1, h1, v1, hs1, vs1, av1, fs1, tr1};
        check_rec(1, got, e);
        if (fs1 === 1'b1) fs_cnt1++;
        if (tr1 === 1'b1 && tr_prev1 == 1'b0) tr_rise1++;
        tr_prev1 = tr1;
      end
    end
  end

  // Stimulus: reset schedule; each edge pushes the state expected after it.
  initial begin
    int c = 0;
    reset = 1'b1;
    for (int cyc = 0; cyc < NCYC; cyc++) begin
      reset = (cyc < 2) || (cyc >= R0 && cyc < R0 + 3);
      @(posedge clk);
      if (reset) c = 0;
      else c++;
      q2.push_back(model(c, 2));
      q1.push_back(model(c, 1));
      #1;
    end
    @(negedge clk);
    #1;
    check_int("queue_drain_pd2", q2.size(), 0);
    check_int("queue_drain_pd1", q1.size(), 0);
    // Hand counts: pd2 frame=330 clk, 2 wraps before the reset, 4 after.
    check_int("frame_start_pulses_pd2", fs_cnt2, 6);
    // pd1 frame=165 clk: 5 wraps before reset, 8 after.
    check_int("frame_start_pulses_pd1", fs_cnt1, 13);
    // pd2 toggles only at the 3rd wrap after the mid-run reset.
    check_int("troca_rises_pd2", tr_rise2, 1);
    check_int("troca_rises_pd1", tr_rise1, 2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
